// File: rtl/if_fetch_unit_if.sv
// Fetch-stage bus bundle: ROM address/data port, branch redirect and the IF/ID handshake.
// The master modport is the fetch unit; the slave modport is its environment.
interface if_fetch_unit_if;
    logic [31:0] inst_addr;
    logic        inst_cs;
    logic [31:0] inst_data;
    logic        rom_stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        fetch_err;

    modport master (
        output inst_addr, inst_cs, if_valid, if_pc, if_inst, fetch_err,
        input  inst_data, rom_stall, branch_taken, branch_target, id_ready
    );

    modport slave (
        input  inst_addr, inst_cs, if_valid, if_pc, if_inst, fetch_err,
        output inst_data, rom_stall, branch_taken, branch_target, id_ready
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the ROM and delivers words over a valid/ready
// IF/ID register with a one-entry skid. Optional stall timeout via IF_FETCH_TIMEOUT_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 64
) (
    input logic            clk,
    input logic            rst,
    if_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {StBoot, StFetch, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] skid_q, skid_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic        valid_q, valid_d;
    logic        cs;
    logic        redirect;

    // Branches are only honoured once the boot cycle is over.
    assign redirect = bus.branch_taken && (state_q != StBoot);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        skid_d     = skid_q;
        skid_pc_d  = skid_pc_q;
        out_pc_d   = out_pc_q;
        out_inst_d = out_inst_q;
        valid_d    = valid_q;
        cs         = 1'b0;

        unique case (state_q)
            StBoot: begin
                state_d = StFetch;
            end
            StFetch: begin
                cs = 1'b1;
                if (redirect) begin
                    pc_d      = bus.branch_target & ~32'h3;
                    valid_d   = 1'b0;
                    skid_d    = '0;
                    skid_pc_d = '0;
                end else if (bus.rom_stall) begin
                    if (valid_q && bus.id_ready) begin
                        valid_d = 1'b0;
                    end
                end else if (!valid_q || bus.id_ready) begin
                    out_inst_d = bus.inst_data;
                    out_pc_d   = pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end else begin
                    // Output still occupied: park the returned word until ID drains.
                    skid_d    = bus.inst_data;
                    skid_pc_d = pc_q;
                    state_d   = StHold;
                end
            end
            StHold: begin
                if (redirect) begin
                    pc_d      = bus.branch_target & ~32'h3;
                    valid_d   = 1'b0;
                    skid_d    = '0;
                    skid_pc_d = '0;
                    state_d   = StFetch;
                end else if (bus.id_ready) begin
                    out_inst_d = skid_q;
                    out_pc_d   = skid_pc_q;
                    valid_d    = 1'b1;
                    pc_d       = pc_q + 32'd4;
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            out_pc_q   <= '0;
            out_inst_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            skid_q     <= skid_d;
            skid_pc_q  <= skid_pc_d;
            out_pc_q   <= out_pc_d;
            out_inst_q <= out_inst_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.inst_addr = pc_q;
    assign bus.inst_cs   = cs;
    assign bus.if_valid  = valid_q;
    assign bus.if_pc     = out_pc_q;
    assign bus.if_inst   = out_inst_q;

`ifdef IF_FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] stall_cnt_q, stall_cnt_d;
    logic            err_q, err_d;

    // Counter saturates at TIMEOUT; the error flag is sticky until reset.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        err_d       = err_q;
        if (!bus.rom_stall || redirect) begin
            stall_cnt_d = '0;
        end else if (state_q == StFetch) begin
            if (stall_cnt_q != CntW'(TIMEOUT)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (stall_cnt_d == CntW'(TIMEOUT)) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.fetch_err = err_q;
`else
    assign bus.fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: latency ROM model, scoreboard of expected deliveries,
// redirect, wrap, skid/HOLD and asynchronous-reset scenarios.
module tb_if_fetch_unit;

    localparam int unsigned STALL = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_fetch_unit_if bus ();

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .TIMEOUT  (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hC0DE_0000 ^ {a[15:0], a[31:16]} ^ 32'h0000_1357;
    endfunction

    // ROM model: every new access stalls STALL cycles before the word is returned.
    logic [31:0] acc_addr  = '0;
    logic        acc_valid = 1'b0;
    int unsigned acc_cnt   = 0;
    logic        force_stall = 1'b0;

    assign bus.rom_stall = force_stall ||
        (bus.inst_cs && (!acc_valid || bus.inst_addr != acc_addr || acc_cnt < STALL - 1));
    assign bus.inst_data = rom_word(bus.inst_addr);

    always @(posedge clk) begin
        if (!bus.inst_cs || !acc_valid || bus.inst_addr != acc_addr) begin
            acc_valid <= bus.inst_cs;
            acc_addr  <= bus.inst_addr;
            acc_cnt   <= 0;
        end else if (acc_cnt < 255) begin
            acc_cnt <= acc_cnt + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard of expected delivered PCs, plus stability monitors.
    logic [31:0] exp_q[$];
    logic        gap_en = 1'b0;
    logic        have_prev = 1'b0;
    int          last_xfer = 0;
    logic        p_addr_hold = 1'b0;
    logic        p_out_hold  = 1'b0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_pc   = '0;
    logic [31:0] p_inst = '0;

    always @(negedge clk) begin
        if (rst) begin
            p_addr_hold <= 1'b0;
            p_out_hold  <= 1'b0;
            have_prev   <= 1'b0;
        end else begin
            if (p_addr_hold) check("addr_stable", bus.inst_addr, p_addr);
            if (p_out_hold) begin
                check("out_pc_stable", bus.if_pc, p_pc);
                check("out_inst_stable", bus.if_inst, p_inst);
            end
            if (bus.if_valid && bus.id_ready) begin
                check("sb_underflow", {31'd0, exp_q.size() == 0}, 32'd0);
                if (exp_q.size() != 0) begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("xfer_pc", bus.if_pc, e);
                    check("xfer_inst", bus.if_inst, rom_word(e));
                end
                if (gap_en && have_prev) check("xfer_gap", cyc - last_xfer, STALL + 1);
                have_prev <= gap_en;
                last_xfer <= cyc;
            end
            p_addr_hold <= bus.inst_cs && bus.rom_stall && !bus.branch_taken;
            p_out_hold  <= bus.if_valid && !bus.id_ready && !bus.branch_taken;
            p_addr      <= bus.inst_addr;
            p_pc        <= bus.if_pc;
            p_inst      <= bus.if_inst;
        end
    end

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        bus.branch_taken  = 1'b0;
        bus.branch_target = '0;
        bus.id_ready      = 1'b1;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_valid", bus.if_valid, 0);
        check("rst_pc", bus.if_pc, 0);
        check("rst_inst", bus.if_inst, 0);
        check("rst_cs", bus.inst_cs, 0);
        check("rst_addr", bus.inst_addr, 0);
        check("rst_err", bus.fetch_err, 0);

        // Boot then sequential streaming with id_ready held high
        exp_q = '{32'd0, 32'd4, 32'd8, 32'd12};
        gap_en = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk); check("boot_cs", bus.inst_cs, 0);
        @(negedge clk); check("fetch_cs", bus.inst_cs, 1);
        check("fetch_addr", bus.inst_addr, 0);
        wait_drain("stream_drain", 80);
        gap_en = 1'b0;

        // Back-pressure: second word lands in the skid, HOLD drops chip-select
        exp_q.push_back(32'd16);
        exp_q.push_back(32'd20);
        exp_q.push_back(32'd24);
        @(posedge clk); #1 bus.id_ready = 1'b0;
        for (int i = 0; i < 60 && bus.inst_cs; i++) @(negedge clk);
        check("hold_cs", bus.inst_cs, 0);
        check("hold_valid", bus.if_valid, 1);
        check("hold_pc", bus.if_pc, 16);
        check("hold_inst", bus.if_inst, rom_word(32'd16));
        check("hold_addr", bus.inst_addr, 20);
        repeat (3) @(negedge clk);
        check("hold_cs_late", bus.inst_cs, 0);
        @(posedge clk); #1 bus.id_ready = 1'b1;
        wait_drain("skid_drain", 40);

        // Redirect during a stalled fetch at pc=8
        @(posedge clk); #1 bus.branch_taken = 1'b1; bus.branch_target = 32'd8;
        @(posedge clk); #1 bus.branch_taken = 1'b0;
        repeat (3) @(negedge clk);
        check("br_pre_addr", bus.inst_addr, 8);
        check("br_pre_stall", bus.rom_stall, 1);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        @(posedge clk); #1 bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_0043;
        @(posedge clk); #1 bus.branch_taken = 1'b0;
        @(negedge clk);
        check("br_valid", bus.if_valid, 0);
        check("br_addr", bus.inst_addr, 32'h40);
        wait_drain("br_drain", 40);

        // Flush of a valid word, and PC wrap from the top of the address space
        @(posedge clk); #1 bus.id_ready = 1'b0;
        for (int i = 0; i < 40 && !bus.if_valid; i++) @(negedge clk);
        check("flush_pre_pc", bus.if_pc, 32'h48);
        @(posedge clk); #1 bus.branch_taken = 1'b1; bus.branch_target = 32'hFFFF_FFFC;
        @(posedge clk); #1 bus.branch_taken = 1'b0;
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        bus.id_ready = 1'b1;
        @(negedge clk);
        check("flush_valid", bus.if_valid, 0);
        check("wrap_addr_top", bus.inst_addr, 32'hFFFF_FFFC);
        wait_drain("wrap_drain", 60);

        // Asynchronous reset mid-fetch, then a branch during BOOT is ignored
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", bus.if_valid, 0);
        check("arst_cs", bus.inst_cs, 0);
        check("arst_addr", bus.inst_addr, 0);
        check("arst_pc", bus.if_pc, 0);
        check("arst_inst", bus.if_inst, 0);
        @(posedge clk); #1 rst = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 32'h100;
        @(negedge clk); check("reboot_cs", bus.inst_cs, 0);
        @(posedge clk); #1 bus.branch_taken = 1'b0;
        @(negedge clk);
        check("boot_br_ignored", bus.inst_addr, 0);
        check("reboot_fetch_cs", bus.inst_cs, 1);
        exp_q.push_back(32'h0);
        wait_drain("reboot_drain", 30);

`ifdef IF_FETCH_TIMEOUT_EN
        // Permanent stall: flag rises after exactly 64 stalled FETCH cycles
        @(posedge clk); #1 rst = 1'b1; force_stall = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk);
        repeat (63) @(posedge clk);
        @(negedge clk); check("to_err_63", bus.fetch_err, 0);
        @(posedge clk);
        @(negedge clk); check("to_err_64", bus.fetch_err, 1);
        repeat (5) @(negedge clk);
        check("to_err_sticky", bus.fetch_err, 1);
        #1 rst = 1'b1;
        #1 check("to_err_rst", bus.fetch_err, 0);
        force_stall = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
`else
        check("err_off", bus.fetch_err, 0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
